// File: rtl/sseg_share_arbiter_if.sv
// Handshake bundle shared by the NoC and CPU display sources.
//   noc_valid / noc_data : NoC word present this cycle; bits [23:0] are six hex digits
//   cpu_req / cpu_data   : level request from the processor, held until cpu_ack
//   cpu_ack              : one-cycle pulse when cpu_data has been captured
// master = the sources (NoC + CPU), slave = the arbiter.
interface sseg_share_arbiter_if;
  logic        noc_valid;
  logic [31:0] noc_data;
  logic        cpu_req;
  logic [23:0] cpu_data;
  logic        cpu_ack;

  modport master (
    output noc_valid, noc_data, cpu_req, cpu_data,
    input  cpu_ack
  );

  modport slave (
    input  noc_valid, noc_data, cpu_req, cpu_data,
    output cpu_ack
  );
endinterface

// File: rtl/sseg_share_arbiter.sv
// Shares a six-digit seven-segment display between a NoC source and a CPU source.
// A granted source owns the display for at least HOLD_CYCLES cycles; ties and
// contention at hold expiry are resolved round-robin. A debounced-by-sync
// pushbutton toggles a freeze mode that stalls the hold timer and captures.
//   clk, reset_n     : system clock, asynchronous active-low reset
//   bus (slave)      : NoC / CPU handshake bundle
//   freeze_n         : asynchronous active-low pushbutton
//   hex0..hex5       : active-low segments (bit0=a .. bit6=g), hexN = digit [4N+3:4N]
//   owner            : 00 none, 01 NoC, 10 CPU
//   led              : [0] frozen, [2:1] owner, [7:3] dropped-NoC count (saturating)
//
// state    | meaning
// IDLE     | no owner; last captured value stays on the display
// SHOW_NOC | NoC owns the display; further NoC words refresh it
// SHOW_CPU | CPU owns the display; NoC words are dropped
module sseg_share_arbiter #(
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sseg_share_arbiter_if.slave  bus,
  input  logic                 freeze_n,
  output logic [6:0]           hex0,
  output logic [6:0]           hex1,
  output logic [6:0]           hex2,
  output logic [6:0]           hex3,
  output logic [6:0]           hex4,
  output logic [6:0]           hex5,
  output logic [1:0]           owner,
  output logic [7:0]           led
);

  // State encodings double as the owner code.
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    SHOW_NOC = 2'b01,
    SHOW_CPU = 2'b10
  } state_t;

  localparam logic SRC_NOC = 1'b0;
  localparam logic SRC_CPU = 1'b1;
  localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t             state_q, state_d;
  logic [23:0]        disp_q, disp_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic               rr_q, rr_d;
  logic               valid_q, valid_d;
  logic               ack_q, ack_d;
  logic               frozen_q, frozen_d;
  logic               sync1_q, sync2_q, sync_prev_q;
  logic [4:0]         drop_q, drop_d;
  logic [1:0]         owner_q;
  logic [6:0]         hex_q [6];

  logic               noc_pend, cpu_pend;
  logic               grant_noc, grant_cpu, refresh;
  logic               drop_inc;
  logic               unused_noc_hi;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign unused_noc_hi = ^bus.noc_data[31:24];

  assign noc_pend = bus.noc_valid;
  // The request is still high while the ack is on the wire; only a request
  // seen after the ack cycle counts as a new one.
  assign cpu_pend = bus.cpu_req & ~ack_q;

  always_comb begin
    state_d   = state_q;
    disp_d    = disp_q;
    hold_d    = hold_q;
    rr_d      = rr_q;
    valid_d   = valid_q;
    ack_d     = 1'b0;
    grant_noc = 1'b0;
    grant_cpu = 1'b0;
    refresh   = 1'b0;

    if (!frozen_q) begin
      case (state_q)
        IDLE: begin
          if (noc_pend && cpu_pend) begin
            if (rr_q == SRC_CPU) grant_noc = 1'b1;
            else                 grant_cpu = 1'b1;
          end else if (noc_pend) begin
            grant_noc = 1'b1;
          end else if (cpu_pend) begin
            grant_cpu = 1'b1;
          end
        end
        SHOW_NOC: begin
          if (hold_q != '0) begin
            hold_d  = hold_q - CNT_W'(1);
            refresh = noc_pend;
          end else if (cpu_pend) begin
            grant_cpu = 1'b1;
          end else if (noc_pend) begin
            grant_noc = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        SHOW_CPU: begin
          if (hold_q != '0) begin
            hold_d = hold_q - CNT_W'(1);
          end else if (noc_pend) begin
            grant_noc = 1'b1;
          end else if (cpu_pend) begin
            grant_cpu = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Refresh keeps the running hold count; a grant restarts it.
    if (refresh) disp_d = bus.noc_data[23:0];

    if (grant_noc) begin
      disp_d  = bus.noc_data[23:0];
      hold_d  = HOLD_RELOAD;
      state_d = SHOW_NOC;
      rr_d    = SRC_NOC;
      valid_d = 1'b1;
    end

    if (grant_cpu) begin
      disp_d  = bus.cpu_data;
      hold_d  = HOLD_RELOAD;
      state_d = SHOW_CPU;
      rr_d    = SRC_CPU;
      valid_d = 1'b1;
      ack_d   = 1'b1;
    end

    // Any NoC word not taken into disp_reg is lost.
    drop_inc = noc_pend & ~(grant_noc | refresh);
    drop_d   = (drop_inc && (drop_q != 5'd31)) ? drop_q + 5'd1 : drop_q;

    frozen_d = frozen_q ^ (sync_prev_q & ~sync2_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      disp_q      <= '0;
      hold_q      <= '0;
      rr_q        <= SRC_CPU;
      valid_q     <= 1'b0;
      ack_q       <= 1'b0;
      frozen_q    <= 1'b0;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      sync_prev_q <= 1'b1;
      drop_q      <= '0;
      owner_q     <= 2'b00;
      for (int i = 0; i < 6; i++) hex_q[i] <= 7'h7F;
    end else begin
      state_q     <= state_d;
      disp_q      <= disp_d;
      hold_q      <= hold_d;
      rr_q        <= rr_d;
      valid_q     <= valid_d;
      ack_q       <= ack_d;
      frozen_q    <= frozen_d;
      sync1_q     <= freeze_n;
      sync2_q     <= sync1_q;
      sync_prev_q <= sync2_q;
      drop_q      <= drop_d;
      owner_q     <= state_q;
      // Blank until something has been captured since reset.
      for (int i = 0; i < 6; i++)
        hex_q[i] <= valid_q ? seg7(disp_q[4*i +: 4]) : 7'h7F;
    end
  end

  assign hex0        = hex_q[0];
  assign hex1        = hex_q[1];
  assign hex2        = hex_q[2];
  assign hex3        = hex_q[3];
  assign hex4        = hex_q[4];
  assign hex5        = hex_q[5];
  assign owner       = owner_q;
  assign bus.cpu_ack = ack_q;
  assign led         = {drop_q, owner_q, frozen_q};

endmodule
